fetch_dispatch_fsm: RTL and testbench

//  Instruction fetch/decode/dispatch controller; sits directly upstream of the execution FSMs (MOV unit, ALU unit).

---
 rtl/fetch_dispatch_fsm.sv | 176 +++++++++++++++++
 tb/tb_fetch_dispatch_fsm.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_dispatch_fsm.sv
// ---------------------------------------------------------------------------
// fetch_dispatch_fsm
//   Instruction fetch / decode / dispatch controller that sits in front of the
//   MOV and ALU execution units. It reads one instruction at a time from a
//   synchronous instruction memory and latches it into IR.
//   - NOP, JMP and HALT complete inside this block.
//   - MOV-class (9, 10) and ALU-class (0-7) instructions get a one-cycle start
//     pulse to the owning unit. The controller then waits for that unit's done
//     pulse, bounded by TIMEOUT cycles, before it fetches again.
//   - Opcodes 12-14 are skipped and set a sticky illegal_op flag.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   run                    allow fetching (sampled in IDLE and on every return
//                          to FETCH)
//   imem_rd_en, imem_addr  instruction memory read strobe / address (= pc)
//   imem_rdata             instruction word, valid one cycle after imem_rd_en
//   opcode, operand        IR fields, stable from DECODE through EXEC_WAIT
//   mov_start, alu_start   one-cycle start pulses to the execution units
//   mov_done, alu_done     completion pulses from the execution units
//   pc                     program counter
//   halted                 high while in HALTED
//   illegal_op             sticky: an opcode in 12-14 was decoded
//   timeout_err            sticky: the selected unit missed its done
// ---------------------------------------------------------------------------
module fetch_dispatch_fsm #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic               mov_start,
  output logic               alu_start,
  input  logic               mov_done,
  input  logic               alu_done,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               illegal_op,
  output logic               timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_DISPATCH  = 3'd4;
  localparam logic [2:0] S_EXEC_WAIT = 3'd5;
  localparam logic [2:0] S_HALTED    = 3'd6;

  logic [2:0]         state, stateNext;
  logic [PC_W-1:0]    pcNext;
  logic [INSTR_W-1:0] ir, irNext;
  logic [TMR_W-1:0]   timer, timerNext;
  logic               illegalNext, timeoutNext;

  // Opcode classes, decoded straight from IR (IR only changes in LOAD, so
  // these stay stable across DISPATCH and EXEC_WAIT).
  logic isAlu, isMov, isJmp, isHalt, isIllegal;
  logic selDone;
  logic [PC_W-1:0]    jmpTarget;
  logic [2:0]         nextFetch;

  assign opcode    = ir[INSTR_W-1 -: 4];
  assign operand   = ir[INSTR_W-5:0];

  assign isAlu     = (opcode[3] == 1'b0);
  assign isMov     = (opcode == 4'd9) || (opcode == 4'd10);
  assign isJmp     = (opcode == 4'd11);
  assign isHalt    = (opcode == 4'd15);
  assign isIllegal = (opcode == 4'd12) || (opcode == 4'd13) || (opcode == 4'd14);

  // Only the unit that was started can complete the instruction.
  assign selDone   = isMov ? mov_done : alu_done;

  // Where an instruction goes once it has finished.
  assign nextFetch = run ? S_FETCH : S_IDLE;

  // JMP target is the low PC_W bits of the operand (zero-extended if the
  // operand field is narrower than the PC).
  generate
    if (PC_W <= INSTR_W - 4) begin : gJmpNarrow
      assign jmpTarget = operand[PC_W-1:0];
    end else begin : gJmpWide
      assign jmpTarget = {{(PC_W - (INSTR_W - 4)){1'b0}}, operand};
    end
  endgenerate

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    irNext      = ir;
    timerNext   = timer;
    illegalNext = illegal_op;
    timeoutNext = timeout_err;
    case (state)
      S_IDLE: begin
        if (run) stateNext = S_FETCH;
      end
      S_FETCH: begin
        stateNext = S_LOAD;
      end
      S_LOAD: begin
        irNext    = imem_rdata;
        pcNext    = pc + PC_W'(1);
        stateNext = S_DECODE;
      end
      S_DECODE: begin
        if (isAlu || isMov) begin
          stateNext = S_DISPATCH;
        end else if (isHalt) begin
          stateNext = S_HALTED;
        end else begin
          if (isJmp)     pcNext      = jmpTarget;
          if (isIllegal) illegalNext = 1'b1;
          stateNext = nextFetch;
        end
      end
      S_DISPATCH: begin
        timerNext = '0;
        stateNext = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        // A done in the final allowed cycle still completes normally.
        if (selDone) begin
          stateNext = nextFetch;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          timeoutNext = 1'b1;
          stateNext   = S_HALTED;
        end else begin
          timerNext = timer + TMR_W'(1);
        end
      end
      S_HALTED: begin
        stateNext = S_HALTED;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      timer       <= '0;
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      ir          <= irNext;
      timer       <= timerNext;
      illegal_op  <= illegalNext;
      timeout_err <= timeoutNext;
    end
  end

  // Moore outputs: decoded from state (and the stable IR) only.
  assign imem_rd_en = (state == S_FETCH);
  assign imem_addr  = pc;
  assign mov_start  = (state == S_DISPATCH) && isMov;
  assign alu_start  = (state == S_DISPATCH) && isAlu;
  assign halted     = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
module tb_fetch_dispatch_fsm;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 16;

  localparam int EV_FETCH = 0;
  localparam int EV_MOV   = 1;
  localparam int EV_ALU   = 2;
  localparam int EV_HALT  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        mov_start, alu_start;
  logic        mov_done = 1'b0;
  logic        alu_done = 1'b0;
  logic [7:0]  pc;
  logic        halted, illegal_op, timeout_err;

  always #5 clk = ~clk;

  fetch_dispatch_fsm #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .opcode(opcode), .operand(operand),
    .mov_start(mov_start), .alu_start(alu_start),
    .mov_done(mov_done), .alu_done(alu_done),
    .pc(pc), .halted(halted), .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  // Synchronous instruction memory: data one cycle after the read strobe.
  logic [15:0] mem [0:255];
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  typedef struct { int kind; int addr; int instr; int ill; int te; } ev_t;
  ev_t expQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int txn = 0;
  bit monEn = 1'b0;
  bit prevHalted = 1'b0;
  bit modelHalted = 1'b0;

  // Responder controls
  int respMode = 0;      // 0 normal, 1 only the wrong unit answers, 2 hold until released
  int respDelay = 1;
  bit respRand = 1'b0;
  bit respNoise = 1'b0;
  bit releaseDone = 1'b0;
  bit runRand = 1'b0;

  task automatic pushEv(input int kind, input int addr, input int instr, input int ill, input int te);
    ev_t e;
    e.kind = kind; e.addr = addr; e.instr = instr; e.ill = ill; e.te = te;
    expQ.push_back(e);
  endtask

  // Reference model: walks the program in mem as an instruction-level
  // interpreter and lists the externally visible events in order.
  task automatic modelWalk(input int maxInstr, input bit noDone);
    int p;
    int ill;
    int op;
    logic [15:0] w;
    p = 0;
    ill = 0;
    modelHalted = 1'b0;
    for (int i = 0; i < maxInstr; i++) begin
      pushEv(EV_FETCH, p, 0, ill, 0);
      w  = mem[p];
      op = int'(w[15:12]);
      p  = (p + 1) % 256;
      if (op < 8 || op == 9 || op == 10) begin
        pushEv((op < 8) ? EV_ALU : EV_MOV, 0, int'(w), 0, 0);
        if (noDone) begin
          pushEv(EV_HALT, 0, 0, ill, 1);
          modelHalted = 1'b1;
          return;
        end
      end else if (op == 11) begin
        p = int'(w[7:0]);
      end else if (op == 15) begin
        pushEv(EV_HALT, 0, 0, ill, 0);
        modelHalted = 1'b1;
        return;
      end else if (op >= 12) begin
        ill = 1;
      end
    end
  endtask

  task automatic observe(input int kind, input int addr, input int instr, input int ill, input int te);
    ev_t e;
    checks++;
    txn++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%02h instr=%04h, required no event", kind, addr, instr);
      return;
    end
    e = expQ.pop_front();
    if (kind != e.kind || addr != e.addr || instr != e.instr || ill != e.ill || te != e.te) begin
      errors++;
      $display("FAIL event: got kind=%0d addr=%02h instr=%04h ill=%0d te=%0d, required kind=%0d addr=%02h instr=%04h ill=%0d te=%0d",
               kind, addr, instr, ill, te, e.kind, e.addr, e.instr, e.ill, e.te);
    end else begin
      $display("txn %0d kind=%0d addr=%02h instr=%04h ill=%0d te=%0d ok", txn, kind, addr, instr, ill, te);
    end
    if (e.kind == EV_HALT && e.te == 1) begin
      checks++;
      if (cyc - startCyc != TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_latency: got %0d cycles, required %0d", cyc - startCyc, TIMEOUT + 1);
      end
    end
  endtask

  // Monitor: one observable event per cycle at most.
  initial begin
    int kind;
    forever begin
      @(negedge clk);
      cyc++;
      if (monEn && !reset) begin
        if (imem_rd_en) begin
          observe(EV_FETCH, int'(imem_addr), 0, int'(illegal_op), 0);
        end else if (mov_start || alu_start) begin
          kind = (mov_start && alu_start) ? 99 : (mov_start ? EV_MOV : EV_ALU);
          startCyc = cyc;
          observe(kind, 0, int'({opcode, operand}), 0, 0);
        end else if (halted && !prevHalted) begin
          observe(EV_HALT, 0, 0, int'(illegal_op), int'(timeout_err));
        end
      end
      prevHalted = halted;
    end
  end

  // Execution-unit responder.
  initial begin
    bit pend;
    bit pendMov;
    int cnt;
    logic [15:0] startWord;
    pend = 1'b0; pendMov = 1'b0; cnt = 0; startWord = '0;
    forever begin
      @(negedge clk);
      mov_done = 1'b0;
      alu_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (mov_start || alu_start) begin
        pend = 1'b1;
        pendMov = mov_start;
        startWord = {opcode, operand};
        cnt = respRand ? int'($urandom_range(6, 1)) : respDelay;
        if (respNoise && ($urandom % 2 == 0)) begin
          if (mov_start) alu_done = 1'b1; else mov_done = 1'b1;
        end
      end else if (pend) begin
        if (respMode == 1) begin
          if (pendMov) alu_done = 1'b1; else mov_done = 1'b1;
        end else if (respMode == 2 && !releaseDone) begin
          cnt = cnt;
        end else begin
          cnt--;
          if (respNoise && ($urandom % 3 == 0)) begin
            if (pendMov) alu_done = 1'b1; else mov_done = 1'b1;
          end
          if (cnt <= 0) begin
            checks++;
            if ({opcode, operand} !== startWord) begin
              errors++;
              $display("FAIL ir_hold: got %04h at done, required %04h", {opcode, operand}, startWord);
            end
            if (pendMov) mov_done = 1'b1; else alu_done = 1'b1;
            pend = 1'b0;
          end
        end
      end
    end
  end

  // Random run toggling (does not change the event order, only timing).
  initial begin
    forever begin
      @(negedge clk);
      if (runRand) run = ($urandom % 4 != 0);
    end
  end

  task automatic fillNop();
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
  endtask

  task automatic doReset();
    monEn = 1'b0;
    runRand = 1'b0;
    run = 1'b0;
    respMode = 0; respDelay = 1; respRand = 1'b0; respNoise = 1'b0; releaseDone = 1'b0;
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    logic [37:0] all;
    all = {imem_rd_en, imem_addr, opcode, operand, mov_start, alu_start, pc, halted, illegal_op, timeout_err};
    checks++;
    if (all !== 38'd0) begin
      errors++;
      $display("FAIL %s: got outputs %010h, required all zero", tag, all);
    end else begin
      $display("txn %s outputs zero ok", tag);
    end
  endtask

  task automatic checkFlags(input string tag, input bit h, input bit ill, input bit te);
    checks++;
    if (halted !== h || illegal_op !== ill || timeout_err !== te) begin
      errors++;
      $display("FAIL %s: got halted=%0b illegal=%0b timeout=%0b, required %0b %0b %0b",
               tag, halted, illegal_op, timeout_err, h, ill, te);
    end else begin
      $display("txn %s flags ok", tag);
    end
  endtask

  task automatic waitQ(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (expQ.size() > target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expQ.size() > target) begin
      errors++;
      $display("FAIL %s: got %0d events pending after %0d cycles, required %0d", tag, expQ.size(), budget, target);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fetches;
    fillNop();
    doReset();
    checkZero("reset_state");

    // MOV dispatch, JMP, illegal skip, HALT
    fillNop();
    mem[0] = 16'h9005; mem[1] = 16'hB0A0;
    mem[8'hA0] = 16'hD000; mem[8'hA1] = 16'h8000; mem[8'hA2] = 16'hF000;
    modelWalk(10, 1'b0);
    respDelay = 4;
    monEn = 1'b1; run = 1'b1;
    waitQ(0, 200, "drain_prog1");
    repeat (20) @(posedge clk);
    checkFlags("after_halt", 1'b1, 1'b1, 1'b0);

    // ALU op answered only by the MOV unit -> timeout
    doReset();
    fillNop();
    mem[0] = 16'h3123;
    modelWalk(5, 1'b1);
    respMode = 1;
    monEn = 1'b1; run = 1'b1;
    waitQ(0, 100, "drain_timeout");
    checkFlags("timeout", 1'b1, 1'b0, 1'b1);

    // Done in the very last allowed cycle wins
    doReset();
    fillNop();
    mem[0] = 16'h2777; mem[1] = 16'hF000;
    modelWalk(5, 1'b0);
    respDelay = TIMEOUT;
    monEn = 1'b1; run = 1'b1;
    waitQ(0, 100, "drain_limit");
    checkFlags("done_at_limit", 1'b1, 1'b0, 1'b0);

    // PC wrap 0xFF -> 0x00
    doReset();
    fillNop();
    mem[0] = 16'hB0FF; mem[8'hFF] = 16'h8000;
    modelWalk(3, 1'b0);
    monEn = 1'b1; run = 1'b1;
    waitQ(0, 100, "drain_wrap");
    monEn = 1'b0;

    // run dropped during EXEC_WAIT -> IDLE after done, resume on run
    doReset();
    fillNop();
    mem[0] = 16'hA042; mem[1] = 16'hF000;
    modelWalk(5, 1'b0);
    respMode = 2;
    monEn = 1'b1; run = 1'b1;
    waitQ(2, 100, "wait_mov_start");
    @(posedge clk);
    run = 1'b0;
    repeat (3) @(posedge clk);
    releaseDone = 1'b1;
    fetches = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_rd_en) fetches++;
    end
    checks++;
    if (fetches != 0 || expQ.size() != 2) begin
      errors++;
      $display("FAIL idle_after_done: got %0d fetches %0d pending, required 0 fetches 2 pending", fetches, expQ.size());
    end
    run = 1'b1;
    waitQ(0, 100, "drain_run");
    checkFlags("run_resume", 1'b1, 1'b0, 1'b0);

    // Async reset during EXEC_WAIT, then restart from address 0
    doReset();
    fillNop();
    mem[0] = 16'hC000; mem[1] = 16'h0555;
    modelWalk(2, 1'b0);
    respMode = 2;
    monEn = 1'b1; run = 1'b1;
    waitQ(0, 100, "drain_pre_reset");
    repeat (3) @(posedge clk);
    monEn = 1'b0;
    #1 reset = 1'b1;
    #1 checkZero("async_reset");
    expQ.delete();
    respMode = 0; releaseDone = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    modelWalk(1, 1'b0);
    monEn = 1'b1;
    waitQ(0, 50, "drain_restart");
    monEn = 1'b0;

    // Randomised programs
    for (int s = 0; s < 8; s++) begin
      doReset();
      for (int i = 0; i < 256; i++) begin
        int r;
        logic [11:0] opnd;
        r = int'($urandom % 32);
        opnd = 12'($urandom);
        if (r < 14)      mem[i] = {4'($urandom % 8), opnd};
        else if (r < 20) mem[i] = {((r % 2) == 0) ? 4'd9 : 4'd10, opnd};
        else if (r < 25) mem[i] = {4'd8, opnd};
        else if (r < 28) mem[i] = {4'd11, opnd};
        else if (r < 30) mem[i] = {4'd12 + 4'(r % 3), opnd};
        else if (r == 30) mem[i] = {4'd15, opnd};
        else             mem[i] = {4'd8, opnd};
      end
      modelWalk(40, 1'b0);
      respRand = 1'b1; respNoise = 1'b1;
      monEn = 1'b1; runRand = 1'b1;
      waitQ(0, 3000, "drain_random");
      if (modelHalted) repeat (8) @(posedge clk);
      monEn = 1'b0;
      runRand = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
